// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer states and
// memory geometry constants.
package dmem_arb_pkg;

  // Three-phase access sequence: pick a winner, drive memory, report back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Every access is one 32-bit word.
  localparam int WORD_BYTES = 4;

  // Default size of the shared data memory in bytes.
  localparam int DEFAULT_DEPTH_BYTES = 1024;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin picker. The search starts at the requester
// after last_grant and wraps, so the most recent winner has lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  // One extra bit so start + offset never overflows before wrapping.
  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

  logic [IDX_W:0]   start_raw;
  logic [IDX_W:0]   start_w;
  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   pos;
  logic [IDX_W:0]   sum;
  logic [IDX_W:0]   wrapped;

  // Rotate the request vector so bit 0 is the first candidate, pick the
  // lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    start_raw = {1'b0, last_grant} + (IDX_W + 1)'(1);
    start_w   = (start_raw >= N_W) ? '0 : start_raw;
    rot       = (req >> start_w) | (req << (N_W - start_w));
    pos       = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pos = (IDX_W + 1)'(j);
      end
    end
    sum       = start_w + pos;
    wrapped   = (sum >= N_W) ? (sum - N_W) : sum;
    grant_idx = IDX_W'(wrapped);
    grant     = (|req) ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing a single-port data memory among
// N_REQ word requesters. Each access takes IDLE -> ISSUE -> RESP.
// Optional address checking is enabled with `define DMEM_ARB_ERRCHK_EN:
// misaligned or out-of-range accesses then never strobe the memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      we,
  input  logic [32*N_REQ-1:0]   addr,
  input  logic [32*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]      ack,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata
);

  localparam int IDX_W = $clog2(N_REQ);

  // Reject unsupported configurations at elaboration time.
  if (N_REQ < 2 || N_REQ > 8 || DEPTH_BYTES < WORD_BYTES) begin : g_param_check
    $error("dmem_arbiter: unsupported N_REQ or DEPTH_BYTES");
  end

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [N_REQ-1:0] grant_reg;
  logic             we_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic             err_reg;
  logic [31:0]      rdata_reg;

  logic [N_REQ-1:0] grant_oh;
  logic [IDX_W-1:0] grant_idx;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             access_err;
  logic             start_access;

  logic [31:0] addr_arr  [N_REQ];
  logic [31:0] wdata_arr [N_REQ];

  // Unpack the flat per-requester buses into word arrays.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[32*gi +: 32];
    assign wdata_arr[gi] = wdata[32*gi +: 32];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  assign sel_addr     = addr_arr[grant_idx];
  assign sel_wdata    = wdata_arr[grant_idx];
  assign start_access = (state_reg == IDLE) && (|req);

`ifdef DMEM_ARB_ERRCHK_EN
  // Highest byte address at which a full word still fits in memory.
  localparam logic [31:0] MAX_WORD_ADDR = 32'(DEPTH_BYTES - WORD_BYTES);

  // Flag misaligned or out-of-range accesses of the current winner.
  assign access_err = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_WORD_ADDR);
`else
  assign access_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode; outputs depend only on registered state.
  always_comb begin
    state_next = state_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ack        = '0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!err_reg) begin
          mem_write = we_reg;
          mem_read  = !we_reg;
        end
        state_next = RESP;
      end
      RESP: begin
        ack        = grant_reg;
        err        = err_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winner in IDLE, capture read data and advance the
  // round-robin pointer at the end of ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= IDX_W'(N_REQ - 1);
      idx_reg        <= '0;
      grant_reg      <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      if (start_access) begin
        idx_reg   <= grant_idx;
        grant_reg <= grant_oh;
        we_reg    <= we[grant_idx];
        addr_reg  <= sel_addr;
        wdata_reg <= sel_wdata;
        err_reg   <= access_err;
      end
      if (state_reg == ISSUE) begin
        rdata_reg      <= (!we_reg && !err_reg) ? mem_rdata : 32'd0;
        last_grant_reg <= idx_reg;
      end
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a word memory model.
// Error-check expectations follow DMEM_ARB_ERRCHK_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  logic        load_mem;
  int          rd_cnt;
  int          wr_cnt;
  int          checks;
  int          errors;

  dmem_arbiter #(
    .N_REQ       (2),
    .DEPTH_BYTES (1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[1]   <= 32'h0000_1111;
      mem[2]   <= 32'd19256;
      mem[255] <= 32'hCAFE_0001;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Strobe pulse counters.
  always @(posedge clk) begin
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access; call and return at posedge+1 in IDLE.
  task automatic access(input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input bit exp_err, input bit exp_strobe, input string tag);
    int rd0;
    int wr0;
    logic [1:0] oh;
    oh  = 2'b01 << p;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req[p]          = 1'b1;
    we[p]           = w;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
    @(posedge clk); #1;
    chk({tag, " issue mem_read"}, 32'(mem_read), 32'(exp_strobe && !w));
    chk({tag, " issue mem_write"}, 32'(mem_write), 32'(exp_strobe && w));
    chk({tag, " issue ack"}, 32'(ack), 32'd0);
    if (exp_strobe) chk({tag, " mem_addr"}, mem_addr, a);
    if (exp_strobe && w) chk({tag, " mem_wdata"}, mem_wdata, d);
    @(posedge clk); #1;
    chk({tag, " ack"}, 32'(ack), 32'(oh));
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " resp strobes"}, 32'({mem_read, mem_write}), 32'd0);
    req[p] = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle ack"}, 32'(ack), 32'd0);
    chk({tag, " read pulses"}, 32'(rd_cnt - rd0), 32'(exp_strobe && !w));
    chk({tag, " write pulses"}, 32'(wr_cnt - wr0), 32'(exp_strobe && w));
    $display("txn %s: port %0d we %0d addr %0h ack %b err %0d rdata %0h",
             tag, p, w, a, oh, err, rdata);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    reset    = 1'b0;
    load_mem = 1'b1;
    req      = '0;
    we       = '0;
    addr     = '0;
    wdata    = '0;

    // Reset state.
    @(posedge clk); #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset strobes", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1;
    load_mem = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single load, then store/readback, then set last winner to port 1.
    access(0, 1'b0, 32'd8,  32'd0,         32'd19256,     1'b0, 1'b1, "load0_a8");
    access(1, 1'b1, 32'd16, 32'hDEADBEEF,  32'd0,         1'b0, 1'b1, "store1_a16");
    access(0, 1'b0, 32'd16, 32'd0,         32'hDEADBEEF,  1'b0, 1'b1, "load0_a16");
    access(1, 1'b0, 32'd8,  32'd0,         32'd19256,     1'b0, 1'b1, "load1_a8");

    // Both ports held: expect 0,1,0,1 with acks three cycles apart.
    we             = 2'b00;
    addr[31:0]     = 32'd8;
    addr[63:32]    = 32'd16;
    req            = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic [1:0]  exp_oh;
      logic [31:0] exp_rd;
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd = (t % 2 == 0) ? 32'd19256 : 32'hDEADBEEF;
      @(posedge clk); #1;
      chk("rr issue ack", 32'(ack), 32'd0);
      chk("rr issue mem_read", 32'(mem_read), 32'd1);
      @(posedge clk); #1;
      chk("rr ack order", 32'(ack), 32'(exp_oh));
      chk("rr rdata", rdata, exp_rd);
      if (t == 3) req = 2'b00;
      @(posedge clk); #1;
      chk("rr idle ack", 32'(ack), 32'd0);
      $display("txn rr%0d: ack %b rdata %0h", t, exp_oh, exp_rd);
    end

    // Address checking boundaries.
`ifdef DMEM_ARB_ERRCHK_EN
    access(0, 1'b0, 32'd6,    32'd0, 32'd0, 1'b1, 1'b0, "err_misalign");
    access(0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, 1'b0, "err_range");
`else
    access(0, 1'b0, 32'd6,    32'd0, 32'h0000_1111, 1'b0, 1'b1, "nochk_a6");
    access(0, 1'b0, 32'd1024, 32'd0, 32'd0,         1'b0, 1'b1, "nochk_a1024");
`endif
    access(0, 1'b0, 32'd1020, 32'd0, 32'hCAFE_0001, 1'b0, 1'b1, "load_a1020");

    // Reset during ISSUE of a store.
    req[0]       = 1'b1;
    we[0]        = 1'b1;
    addr[31:0]   = 32'd32;
    wdata[31:0]  = 32'h1234_5678;
    @(posedge clk); #1;
    chk("abort issue mem_write", 32'(mem_write), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort mem_write drop", 32'(mem_write), 32'd0);
    chk("abort mem_read", 32'(mem_read), 32'd0);
    chk("abort ack", 32'(ack), 32'd0);
    req = 2'b00;
    we  = 2'b00;
    @(posedge clk); #1;
    chk("abort hold ack", 32'(ack), 32'd0);
    chk("abort mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    chk("abort hold2 ack", 32'(ack), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post reset ack", 32'(ack), 32'd0);
    access(0, 1'b0, 32'd8, 32'd0, 32'd19256, 1'b0, 1'b1, "post_reset_load0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter and sequencer that shares the single-port byte-addressed data memory among N_REQ word-access requesters, e.g. the CPU load/store unit and a debug/loader port. It sits between the requesters and the memory's Address/WriteData/MemRead/MemWrite/ReadData port. Each access runs a fixed three-state sequence: arbitrate, issue to memory, respond. With error checking compiled in, misaligned and out-of-range accesses are rejected without touching memory.

## Interface
- N_REQ, 2, number of requesters (2..8)
- DEPTH_BYTES, 1024, memory size in bytes; legal word addresses are 0..DEPTH_BYTES-4
- clk  input  1  clock; all state changes on posedge
- reset  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester access request; held high until its ack
- we  input  N_REQ  per-requester write enable (1 = store, 0 = load)
- addr  input  32*N_REQ  byte address; requester i uses bits [32i+31:32i]
- wdata  input  32*N_REQ  store data; same packing as addr
- ack  output  N_REQ  one-cycle completion pulse per requester
- rdata  output  32  load data; valid in the ack cycle
- err  output  1  access rejected; valid in the ack cycle
- mem_addr  output  32  memory Address
- mem_wdata  output  32  memory WriteData
- mem_read  output  1  memory MemRead
- mem_write  output  1  memory MemWrite
- mem_rdata  input  32  memory ReadData, combinational from mem_addr

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, any req bit high:
  - Select a winner by round-robin, starting from the requester after last_grant.
  - Latch the winner's index, we, addr and wdata into registers.
  - Compute the error flag (see Configuration).
  - Go to ISSUE.
- ISSUE:
  - mem_addr and mem_wdata come from the latched registers.
  - No error: mem_write = latched we; mem_read = !latched we.
  - Error: both strobes stay 0.
  - Capture mem_rdata into rdata on the clock edge (loads only, no error). Stores and errors load rdata with 0.
  - Update last_grant to the winner. Go to RESP.
- RESP: assert ack[winner] and err (if flagged) for this cycle only; go to IDLE.
- IDLE with req = 0: remain in IDLE; all strobes 0.
- Protocol rules:
  - A requester must not change we, addr or wdata while req is high.
  - Dropping req before ack does not abort the transaction. It completes and still pulses ack.
  - A requester sampled in IDLE that is still high on return to IDLE is treated as a new request.
- Round-robin guarantee: each continuously requesting port is served at least once every N_REQ transactions.

## Timing
- Reset values:
  - State IDLE, last_grant = N_REQ-1 (requester 0 wins first).
  - ack = 0, rdata = 0, err = 0.
  - mem_addr = 0, mem_wdata = 0, mem_read = 0, mem_write = 0.
- Latency: req seen at edge k, memory strobe during cycle k+1, ack high during cycle k+2.
- Throughput: one transaction per 3 cycles; the next grant is decided in the IDLE cycle after RESP.
- mem_read and mem_write are decoded from registered state only and are high for exactly one cycle.
- Simultaneous requests: only the round-robin winner proceeds; the others wait with req held.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and strobes drop asynchronously.
  - A store in ISSUE is not guaranteed to be written.
  - No ack is issued for the aborted transaction.

## Configuration
- DMEM_ARB_ERRCHK_EN defined:
  - err = 1 when addr[1:0] != 0 or addr > DEPTH_BYTES-4.
  - An erroring access asserts no memory strobe and returns rdata = 0.
- DMEM_ARB_ERRCHK_EN undefined:
  - Address passes unchecked; err is tied to 0.
  - Every access asserts a memory strobe.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - constant WORD_BYTES = 4;
  - the default DEPTH_BYTES.
- Sub-module rr_arbiter:
  - combinational round-robin picker;
  - inputs: req vector and last_grant; outputs: one-hot grant and encoded index.

## Test plan
- Single load, requester 0 at addr 8 with memory word 19256: ack[0] in cycle 2 after req; rdata = 19256; err = 0; mem_read high for exactly one cycle.
- Store from requester 1 of 0xDEADBEEF to addr 16, then load addr 16 from requester 0: the load returns 0xDEADBEEF; mem_write pulses once.
- Both requesters held high for 4 transactions: ack order is 0, 1, 0, 1, spaced 3 cycles apart.
- With DMEM_ARB_ERRCHK_EN, load at addr 6 and load at addr 1024: err = 1 and rdata = 0 for each; no mem_read or mem_write pulse.
- reset driven low during ISSUE of a store: mem_write drops immediately; no ack; after release, the next request from requester 0 completes normally.
